// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for PMIPSL0: registers the decoded control bundle and operands,
// detects load-use hazards (one bubble plus upstream stall) and honours flush/hold.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [1:0]        id_PCControl,
  input  logic              id_RegWrite,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_ALUOp,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_MemtoReg,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc1,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [1:0]        ex_PCControl,
  output logic              ex_RegWrite,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_ALUOp,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_MemtoReg,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_dest,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc1,
  output logic              stall,
  output logic [7:0]        bubble_count
);

  typedef struct packed {
    logic [1:0] pc_control;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       alu_op;
    logic       branch;
    logic       jump;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc1;
  } stage_t;

  stage_t     stage_q, stage_d;
  ctrl_t      id_ctrl;
  logic [7:0] bubble_count_q, bubble_count_d;
  logic       id_uses_rt;
  logic       hazard;

  assign id_ctrl = '{pc_control: id_PCControl, reg_write: id_RegWrite, reg_dst: id_RegDst,
                     alu_src: id_ALUSrc, alu_op: id_ALUOp, branch: id_Branch, jump: id_Jump,
                     mem_write: id_MemWrite, mem_read: id_MemRead, mem_to_reg: id_MemtoReg};

  // Stores and branches read rt as a register even though ALUSrc selects the immediate.
  assign id_uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch;

  assign hazard = id_valid & stage_q.valid & stage_q.ctrl.mem_read & stage_q.ctrl.reg_write
                & (stage_q.dest != '0)
                & ((stage_q.dest == id_rs) | ((stage_q.dest == id_rt) & id_uses_rt));

  assign stall = ~flush & (hold | hazard);

  always_comb begin
    // NOTE: every variable gets a default up front so no path through the priority chain
    // leaves it unassigned and infers a latch.
    stage_d        = stage_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      stage_d.valid = 1'b0;
      stage_d.ctrl  = '0;
    end else if (!hold) begin
      if (hazard) begin
        stage_d.valid = 1'b0;
        stage_d.ctrl  = '0;
        if (bubble_count_q != 8'hFF) bubble_count_d = bubble_count_q + 8'd1;
      end else begin
        stage_d.valid   = id_valid;
        stage_d.ctrl    = id_valid ? id_ctrl : '0;
        stage_d.rs      = id_rs;
        stage_d.rt      = id_rt;
        stage_d.dest    = id_RegDst ? id_rd : id_rt;
        stage_d.rs_data = id_rs_data;
        stage_d.rt_data = id_rt_data;
        stage_d.imm     = id_imm;
        stage_d.pc1     = id_pc1;
      end
    end
  end

  // NOTE: the data fields are cleared on reset too; it costs nothing here and keeps the
  // whole stage at a known value out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_q        <= '0;
      bubble_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      stage_q        <= stage_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_PCControl = stage_q.ctrl.pc_control;
  assign ex_RegWrite  = stage_q.ctrl.reg_write;
  assign ex_RegDst    = stage_q.ctrl.reg_dst;
  assign ex_ALUSrc    = stage_q.ctrl.alu_src;
  assign ex_ALUOp     = stage_q.ctrl.alu_op;
  assign ex_Branch    = stage_q.ctrl.branch;
  assign ex_Jump      = stage_q.ctrl.jump;
  assign ex_MemWrite  = stage_q.ctrl.mem_write;
  assign ex_MemRead   = stage_q.ctrl.mem_read;
  assign ex_MemtoReg  = stage_q.ctrl.mem_to_reg;
  assign ex_rs        = stage_q.rs;
  assign ex_rt        = stage_q.rt;
  assign ex_dest      = stage_q.dest;
  assign ex_rs_data   = stage_q.rs_data;
  assign ex_rt_data   = stage_q.rt_data;
  assign ex_imm       = stage_q.imm;
  assign ex_pc1       = stage_q.pc1;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a spec-level model compared every negedge,
// plus directed literal checks for reset, load-use, flush, hold, saturation and async reset.
module tb_id_ex_stage;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_PCControl;
  logic        id_RegWrite, id_RegDst, id_ALUSrc, id_ALUOp, id_Branch;
  logic        id_Jump, id_MemWrite, id_MemRead, id_MemtoReg;
  logic [1:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc1;
  logic        flush, hold;
  logic        ex_valid;
  logic [1:0]  ex_PCControl;
  logic        ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch;
  logic        ex_Jump, ex_MemWrite, ex_MemRead, ex_MemtoReg;
  logic [1:0]  ex_rs, ex_rt, ex_dest;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc1;
  logic        stall;
  logic [7:0]  bubble_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  int pc      = 0;

  id_ex_stage #(.DATA_W(16), .RA_W(2)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_PCControl(id_PCControl),
    .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
    .id_ALUOp(id_ALUOp), .id_Branch(id_Branch), .id_Jump(id_Jump),
    .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc1(id_pc1), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_PCControl(ex_PCControl), .ex_RegWrite(ex_RegWrite),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_pc1(ex_pc1), .stall(stall), .bubble_count(bubble_count)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Expected contents of the ID/EX register.
  typedef struct packed {
    logic        valid;
    logic [1:0]  pcc;
    logic        rw, rdst, asrc, aop, br, jmp, mw, mr, m2r;
    logic [1:0]  rs, rt, dest;
    logic [15:0] rsd, rtd, imm, pc1;
  } exp_t;

  exp_t m = '0;
  int   m_cnt = 0;

  function automatic bit model_hazard();
    bit uses_rt = !id_ALUSrc || id_MemWrite || id_Branch;
    if (!(id_valid && m.valid && m.mr && m.rw)) return 0;
    if (m.dest == 2'd0) return 0;
    return (m.dest == id_rs) || (m.dest == id_rt && uses_rt);
  endfunction

  function automatic bit model_stall();
    return !flush && (hold || model_hazard());
  endfunction

  function automatic exp_t as_bubble(exp_t e);
    exp_t b = e;
    b.valid = 0; b.pcc = 0; b.rw = 0; b.rdst = 0; b.asrc = 0; b.aop = 0;
    b.br = 0; b.jmp = 0; b.mw = 0; b.mr = 0; b.m2r = 0;
    return b;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m = '0;
      m_cnt = 0;
    end else if (flush) begin
      m = as_bubble(m);
    end else if (!hold) begin
      if (model_hazard()) begin
        m = as_bubble(m);
        if (m_cnt < 255) m_cnt++;
      end else begin
        m.valid = id_valid;
        {m.pcc, m.rw, m.rdst, m.asrc, m.aop, m.br, m.jmp, m.mw, m.mr, m.m2r} =
          {id_PCControl, id_RegWrite, id_RegDst, id_ALUSrc, id_ALUOp, id_Branch,
           id_Jump, id_MemWrite, id_MemRead, id_MemtoReg};
        if (!id_valid) m = as_bubble(m);
        m.rs = id_rs; m.rt = id_rt; m.dest = id_RegDst ? id_rd : id_rt;
        m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm; m.pc1 = id_pc1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_valid", ex_valid, m.valid);
      check("m_ctrl", {ex_PCControl, ex_RegWrite, ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch,
                       ex_Jump, ex_MemWrite, ex_MemRead, ex_MemtoReg},
            {m.pcc, m.rw, m.rdst, m.asrc, m.aop, m.br, m.jmp, m.mw, m.mr, m.m2r});
      if (m.valid) begin
        check("m_addr", {ex_rs, ex_rt, ex_dest}, {m.rs, m.rt, m.dest});
        check("m_data", {ex_rs_data, ex_rt_data}, {m.rsd, m.rtd});
        check("m_imm_pc", {ex_imm, ex_pc1}, {m.imm, m.pc1});
      end
      check("m_stall", stall, model_stall());
      check("m_count", bubble_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_PCControl = 0; id_RegWrite = 0; id_RegDst = 0; id_ALUSrc = 0;
    id_ALUOp = 0; id_Branch = 0; id_Jump = 0; id_MemWrite = 0; id_MemRead = 0;
    id_MemtoReg = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc1 = 0;
  endtask

  task automatic id_common(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                           input logic [15:0] imm);
    id_clear();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
    id_rs_data = 16'h1000 + 16'(pc); id_rt_data = 16'h2000 + 16'(pc);
    pc++;
    id_pc1 = 16'(pc);
  endtask

  task automatic id_load(input logic [1:0] rs, input logic [1:0] rt, input logic [15:0] imm);
    id_common(rs, rt, 2'd0, imm);
    id_ALUSrc = 1; id_RegWrite = 1; id_MemRead = 1; id_MemtoReg = 1;
  endtask

  task automatic id_add(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd);
    id_common(rs, rt, rd, 16'h0);
    id_RegDst = 1; id_RegWrite = 1; id_ALUOp = 1; id_PCControl = 2'd1;
  endtask

  task automatic id_addi(input logic [1:0] rs, input logic [1:0] rt, input logic [15:0] imm);
    id_common(rs, rt, 2'd0, imm);
    id_ALUSrc = 1; id_RegWrite = 1;
  endtask

  task automatic id_sw(input logic [1:0] rs, input logic [1:0] rt, input logic [15:0] imm);
    id_common(rs, rt, 2'd0, imm);
    id_ALUSrc = 1; id_MemWrite = 1;
  endtask

  initial begin
    id_clear();
    flush = 0;
    hold  = 0;
    reset = 0;

    // Reset held for two cycles: everything reads zero.
    tick(); tick();
    check("rst_valid", ex_valid, 0);
    check("rst_ctrl", {ex_PCControl, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc}, 0);
    check("rst_data", {ex_dest, ex_imm, ex_rs_data, ex_pc1}, 0);
    check("rst_stall", stall, 0);
    check("rst_count", bubble_count, 0);
    chk_en = 1;

    // addi r2 = r0 + 5, captured on the first edge after release.
    id_clear();
    id_valid = 1; id_ALUSrc = 1; id_RegWrite = 1; id_rt = 2; id_imm = 16'd5;
    reset = 1;
    tick();
    check("addi_valid", ex_valid, 1);
    check("addi_regwrite", ex_RegWrite, 1);
    check("addi_alusrc", ex_ALUSrc, 1);
    check("addi_dest", ex_dest, 2);
    check("addi_imm", ex_imm, 5);
    check("addi_stall", stall, 0);

    // Load-use on rs: one bubble, then the add is captured.
    id_load(2'd2, 2'd1, 16'd3);
    tick();
    id_add(2'd1, 2'd3, 2'd2);
    #1 check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_rw", ex_RegWrite, 0);
    check("lu_count", bubble_count, 1);
    check("lu_bubble_stall", stall, 0);
    tick();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_dest", ex_dest, 2);
    check("lu_add_rs", ex_rs, 1);

    // Load to r0 never hazards.
    id_load(2'd2, 2'd0, 16'd4);
    tick();
    id_add(2'd0, 2'd0, 2'd3);
    #1 check("r0_stall", stall, 0);
    tick();
    check("r0_count", bubble_count, 1);

    // addi with rt matching the load dest: rt unused, no hazard.
    id_load(2'd2, 2'd1, 16'd6);
    tick();
    id_addi(2'd2, 2'd1, 16'd9);
    #1 check("addi_rt_stall", stall, 0);
    tick();
    check("addi_rt_valid", ex_valid, 1);
    check("addi_rt_count", bubble_count, 1);

    // Store reads rt as data: hazard.
    id_load(2'd2, 2'd1, 16'd8);
    tick();
    id_sw(2'd2, 2'd1, 16'd2);
    #1 check("sw_stall", stall, 1);
    tick();
    check("sw_bubble", ex_valid, 0);
    check("sw_count", bubble_count, 2);
    tick();

    // Flush beats hold and hazard.
    id_load(2'd2, 2'd1, 16'd1);
    tick();
    id_add(2'd1, 2'd0, 2'd3);
    hold = 1; flush = 1;
    #1 check("fl_stall", stall, 0);
    tick();
    check("fl_valid", ex_valid, 0);
    check("fl_count", bubble_count, 2);
    flush = 0; hold = 0;
    tick();

    // Hold for three cycles (first with a pending hazard): frozen, stall high, count kept.
    id_load(2'd2, 2'd1, 16'd7);
    tick();
    hold = 1;
    id_add(2'd1, 2'd0, 2'd3);
    #1 check("hold_stall0", stall, 1);
    tick();
    id_addi(2'd0, 2'd3, 16'd100);
    tick();
    id_addi(2'd0, 2'd3, 16'd200);
    tick();
    check("hold_imm", ex_imm, 7);
    check("hold_memread", ex_MemRead, 1);
    check("hold_count", bubble_count, 2);
    check("hold_stall", stall, 1);
    hold = 0;
    tick();
    check("hold_resume_imm", ex_imm, 200);

    // Saturation: 260 more load-use bubbles.
    for (int i = 0; i < 260; i++) begin
      id_load(2'd2, 2'd1, 16'(i));
      tick();
      id_add(2'd1, 2'd2, 2'd3);
      tick();
    end
    check("sat_count", bubble_count, 255);

    // Async reset mid-stall, between edges.
    id_load(2'd2, 2'd1, 16'd5);
    tick();
    id_add(2'd1, 2'd2, 2'd3);
    #2 reset = 0;
    #1;
    check("ar_valid", ex_valid, 0);
    check("ar_ctrl", {ex_PCControl, ex_RegWrite, ex_MemRead, ex_MemtoReg, ex_ALUSrc}, 0);
    check("ar_data", {ex_dest, ex_imm, ex_rs_data, ex_rt_data, ex_pc1}, 0);
    check("ar_count", bubble_count, 0);
    check("ar_stall", stall, 0);
    tick();
    reset = 1;
    tick();
    check("ar_recover_valid", ex_valid, 1);
    check("ar_recover_dest", ex_dest, 3);
    check("ar_recover_count", bubble_count, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for PMIPSL0. It sits directly downstream of the `Control` decoder and the register file, and registers the decoded control bundle, operands and immediate into the ID/EX pipeline register. It also detects load-use hazards, inserting one bubble and stalling the upstream IF/ID stage. It honours a flush from branch/jump resolution and a hold from downstream.

## Interface
Parameters:
- DATA_W, 16, datapath width of operands, immediate and PC+1
- RA_W, 2, register address width; register 0 is hardwired zero

Ports (reset is asynchronous, active-low):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears the stage
- id_valid  in  1  IF/ID holds a real instruction
- id_PCControl  in  2  from Control
- id_RegWrite, id_RegDst, id_ALUSrc, id_ALUOp, id_Branch, id_Jump, id_MemWrite, id_MemRead, id_MemtoReg  in  1 each  from Control
- id_rs, id_rt, id_rd  in  RA_W  register fields
- id_rs_data, id_rt_data  in  DATA_W  register file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc1  in  DATA_W  PC+1 of the instruction
- flush  in  1  branch/jump taken in EX; kill the instruction entering ID/EX
- hold  in  1  downstream busy; freeze ID/EX
- ex_valid  out  1  ID/EX holds a real instruction
- ex_PCControl  out  2, and ex_RegWrite … ex_MemtoReg  out  1 each  registered control
- ex_rs, ex_rt  out  RA_W  registered source addresses, for forwarding
- ex_dest  out  RA_W  registered destination: id_rd if id_RegDst=1, else id_rt
- ex_rs_data, ex_rt_data, ex_imm, ex_pc1  out  DATA_W  registered data
- stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_count  out  8  saturating count of hazard bubbles

## Operation
- Bubble: ex_valid=0 with all ex_ control outputs driven 0. Data and address fields may retain stale values but must be ignored.
- Hazard (combinational) is asserted when all of the following hold:
  - id_valid, ex_valid, ex_MemRead and ex_RegWrite are all 1;
  - ex_dest != 0;
  - ex_dest == id_rs, or ex_dest == id_rt and id_uses_rt.
- id_uses_rt = ~id_ALUSrc | id_MemWrite | id_Branch.
- stall = ~flush & (hold | hazard).
- Per-edge update, highest priority first:
  1. flush=1: load a bubble, regardless of hold.
  2. hold=1: keep all ID/EX contents unchanged.
  3. hazard=1: load a bubble and increment bubble_count.
  4. Otherwise: capture all id_ inputs and set ex_valid=id_valid. If id_valid=0, force the controls to 0.
- ex_dest is computed at capture from id_RegDst and is not recomputed later.
- bubble_count increments only on a hazard bubble (not on flush or hold) and saturates at 255.

## Timing
- Reset (reset=0, asynchronous) drives all ex_ outputs, ex_valid and bubble_count to 0 immediately. stall then follows its equation with ex_valid=0.
- On release, the stage captures on the first rising edge where reset=1.
- Latency is one clock: id_ inputs sampled at edge N appear on ex_ outputs after edge N.
- stall is same-cycle combinational and has no registered delay.
- A load-use pair costs exactly one bubble. The stalled instruction stays in IF/ID and captures on the next edge, with forwarding from MEM handling the rest.
- Back-to-back hazards cannot occur on one instruction, because ex_valid=0 after a bubble clears the hazard.
- flush and hazard in the same cycle: flush wins, stall=0, and bubble_count is unchanged.
- hold with hazard: the stage freezes, stall=1, and bubble_count is unchanged.
- Reset asserted mid-hold or mid-stall clears the stage; no pending state survives.

## Test plan
- Reset then addi: hold reset=0 for 2 cycles and check all outputs are 0. Then release with id_valid=1, ALUSrc=1, RegWrite=1, rt=2, imm=5. One cycle later: ex_valid=1, ex_RegWrite=1, ex_ALUSrc=1, ex_dest=2, ex_imm=5, stall=0.
- Load-use: load into r1 is in EX (MemRead=1, RegWrite=1, dest=1), and ID holds an add reading rs=1. Required: stall=1 that cycle; the next cycle ex_valid=0 with controls 0 and bubble_count=1; the following cycle the add is captured.
- No false hazard: the load targets r0, or the ID instruction is addi with rt=1 (rt unused). Required: stall=0 and no bubble.
- Flush priority: flush=1 with hazard=1 and hold=1 in the same cycle. Required: stall=0, the next cycle ex_valid=0, and bubble_count unchanged.
- Hold: hold=1 for 3 cycles with changing id_ inputs. Required: ex_ outputs are frozen and stall=1 throughout; capture resumes when hold=0.
- Saturation and async reset: force 260 hazard bubbles and check bubble_count=255. Then assert reset=0 between clock edges and check all outputs reach 0 before the next edge.
